font_rom_arbiter: RTL and testbench
===================================

# font_rom_arbiter

Shares the single synchronous font ROM between two glyph-row requesters: port A, the text renderer, with a hard per-character deadline, and port B, an auxiliary overlay/cursor generator. It accepts one access at a time over a req/gnt handshake, drives the ROM address, waits out the ROM read latency and returns the 8-bit glyph row to the owning port with a one-cycle valid strobe. Port A has fixed priority. A starvation counter guarantees B service under sustained contention. Sits between the text data generator and the font ROM, on the same clock as the VGA sync logic.

## Interface
- ADDR_W, 11, ROM address width: {7-bit char code, 4-bit glyph row}
- DATA_W, 8, glyph row width
- ROM_LAT, 1, font ROM read latency in clk cycles, ≥1
- STARVE_LIMIT, 4, consecutive A-wins-over-waiting-B before B is forced, ≥1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A request; a_addr must be stable while high
- a_addr  in  ADDR_W  port A ROM address
- a_gnt  out  1  one-cycle pulse: A's request accepted
- a_valid  out  1  one-cycle pulse: a_data updated
- a_data  out  DATA_W  glyph row for A; holds until next a_valid
- b_req, b_addr, b_gnt, b_valid, b_data: same as A, for port B
- rom_addr  out  ADDR_W  registered address to font ROM
- rom_data  in  DATA_W  font ROM output, valid ROM_LAT cycles after rom_addr is sampled
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE, at an edge with any req high:
  - Select owner, latch rom_addr ← owner addr, pulse owner gnt, load lat_cnt ← ROM_LAT − 1, go to WAIT.
  - With no req high, stay in IDLE; rom_addr holds its last value.
- Selection:
  - Only one requester high: that requester wins.
  - Both high: A wins unless starve_cnt == STARVE_LIMIT, in which case B wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when A wins while b_req is high.
  - Clears whenever B is granted.
  - Unchanged otherwise.
- WAIT: decrement lat_cnt each cycle; go to CAPTURE when it reaches 0.
- CAPTURE:
  - owner data ← rom_data, pulse owner valid, return to IDLE.
  - The other port's data and valid are untouched.
- Requesters must drop req in the cycle gnt is seen. A req still high at the next IDLE sample is a new access.
- A req dropped before gnt is withdrawn; no access is made and no state changes.
- One access in flight at most; requests arriving during WAIT or CAPTURE wait in their req line.
- Reset, at any time including mid-access:
  - state ← IDLE; starve_cnt, lat_cnt ← 0.
  - All gnt and valid ← 0; a_data, b_data, rom_addr ← 0.
  - The in-flight access is discarded; no valid is issued for it.

## Timing
- Request sampled at edge k → gnt high during cycle k..k+1 and rom_addr updated after edge k.
- ROM samples rom_addr at edge k+1.
- Data captured at edge k+1+ROM_LAT → valid high for one cycle after it.
- Next arbitration is at edge k+2+ROM_LAT. Throughput is one access per ROM_LAT+2 cycles, i.e. 3 cycles at ROM_LAT=1. This is well inside the 32-clk character cell budget at a tick every 4 clk.
- gnt and valid are registered, are never high for both ports in the same cycle, and never last more than one cycle.
- busy is high from the cycle after the accepting edge through the CAPTURE cycle.

## Test plan
- Single A, ROM_LAT=1: a_req=1, a_addr=0x041 at edge 0.
  - Required: a_gnt in cycle 1, rom_addr=0x041, a_valid in cycle 3 with a_data = ROM[0x041], b_* silent.
- Single B with ROM_LAT=3: b_addr=0x7FF.
  - Required: b_valid 4 edges after acceptance, b_data = ROM[0x7FF], a_data unchanged.
- Simultaneous a_req and b_req, starve_cnt=0.
  - Required: A granted first, B granted at the next IDLE sample (A dropped req), starve_cnt back to 0 after B's grant.
- Both requests held high continuously, STARVE_LIMIT=4.
  - Required: grant order A,A,A,A,B,A,A,A,A,B…, each grant spaced 3 cycles.
- reset asserted during WAIT.
  - Required: next cycle busy=0 and all outputs 0; no a_valid for the aborted access; a fresh a_req then completes normally.
- A withdraws req in the same cycle B's access is in WAIT.
  - Required: after B's valid, no a_gnt; FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : font_rom_arbiter
// Purpose  : Shares one synchronous font ROM between two glyph-row requesters.
//            Port A (text renderer) has fixed priority. Port B (overlay /
//            cursor) is protected from starvation by a counter that forces a
//            B grant after STARVE_LIMIT consecutive A wins over a waiting B.
//            One access is in flight at a time. The FSM grants, then waits
//            out the ROM latency, then captures the row with a one-cycle
//            valid strobe to the owning port.
// Ports    : clk_i, reset_i     - clock, synchronous active-high reset
//            a_req_i/a_addr_i   - port A request and ROM address
//            a_gnt_o/a_valid_o  - port A grant pulse, data-valid pulse
//            a_data_o           - port A glyph row (held until next valid)
//            b_*                - same set for port B
//            rom_addr_o         - registered address to the font ROM
//            rom_data_i         - font ROM output, ROM_LAT cycles after sample
//            busy_o             - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module font_rom_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 8,
   parameter int ROM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              a_req_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   output logic              a_gnt_o,
   output logic              a_valid_o,
   output logic [DATA_W-1:0] a_data_o,
   input  logic              b_req_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   output logic              b_gnt_o,
   output logic              b_valid_o,
   output logic [DATA_W-1:0] b_data_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              busy_o
);

   localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [LAT_W-1:0] C_LAT_LOAD = LAT_W'(ROM_LAT - 1);
   localparam logic [STV_W-1:0] C_STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              owner_b_q, owner_b_d;     // 1: current access belongs to B
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
   logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
   logic              pick_b;

   // B wins when it is alone, or when both request and B has been passed
   // over STARVE_LIMIT times in a row.
   assign pick_b = b_req_i && (!a_req_i || (starve_cnt_q == C_STV_MAX));

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      owner_b_d    = owner_b_q;
      rom_addr_d   = rom_addr_q;
      a_gnt_d      = 1'b0;
      b_gnt_d      = 1'b0;
      a_valid_d    = 1'b0;
      b_valid_d    = 1'b0;
      a_data_d     = a_data_q;
      b_data_d     = b_data_q;

      case (state_q)
         S_IDLE: begin
            if (a_req_i || b_req_i) begin
               owner_b_d  = pick_b;
               rom_addr_d = pick_b ? b_addr_i : a_addr_i;
               a_gnt_d    = !pick_b;
               b_gnt_d    = pick_b;
               lat_cnt_d  = C_LAT_LOAD;
               state_d    = S_WAIT;
               if (pick_b) begin
                  starve_cnt_d = '0;
               end else if (b_req_i && (starve_cnt_q != C_STV_MAX)) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
            end
         end
         // The ROM samples rom_addr on the first WAIT edge; after ROM_LAT
         // WAIT edges its output is ready for the CAPTURE edge.
         S_WAIT: begin
            if (lat_cnt_q == '0) begin
               state_d = S_CAPTURE;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         S_CAPTURE: begin
            if (owner_b_q) begin
               b_data_d  = rom_data_i;
               b_valid_d = 1'b1;
            end else begin
               a_data_d  = rom_data_i;
               a_valid_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         owner_b_q    <= 1'b0;
         rom_addr_q   <= '0;
         a_gnt_q      <= 1'b0;
         b_gnt_q      <= 1'b0;
         a_valid_q    <= 1'b0;
         b_valid_q    <= 1'b0;
         a_data_q     <= '0;
         b_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         owner_b_q    <= owner_b_d;
         rom_addr_q   <= rom_addr_d;
         a_gnt_q      <= a_gnt_d;
         b_gnt_q      <= b_gnt_d;
         a_valid_q    <= a_valid_d;
         b_valid_q    <= b_valid_d;
         a_data_q     <= a_data_d;
         b_data_q     <= b_data_d;
      end
   end

   assign a_gnt_o    = a_gnt_q;
   assign b_gnt_o    = b_gnt_q;
   assign a_valid_o  = a_valid_q;
   assign b_valid_o  = b_valid_q;
   assign a_data_o   = a_data_q;
   assign b_data_o   = b_data_q;
   assign rom_addr_o = rom_addr_q;
   assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_font_rom_arbiter
// Purpose  : Self-checking bench for font_rom_arbiter. Main instance runs at
//            ROM_LAT=1 with a grant/data scoreboard; a second instance at
//            ROM_LAT=3 covers the longer latency path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_font_rom_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        a_req, b_req;
   logic [10:0] a_addr, b_addr;
   logic        a_gnt, b_gnt, a_valid, b_valid, busy;
   logic [7:0]  a_data, b_data, rom_data;
   logic [10:0] rom_addr;

   logic        a_req3, b_req3;
   logic [10:0] a_addr3, b_addr3;
   logic        a_gnt3, b_gnt3, a_valid3, b_valid3, busy3;
   logic [7:0]  a_data3, b_data3, rom_data3;
   logic [10:0] rom_addr3;

   font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .STARVE_LIMIT(4)) u_dut (
      .clk_i(clk), .reset_i(reset),
      .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt), .a_valid_o(a_valid), .a_data_o(a_data),
      .b_req_i(b_req), .b_addr_i(b_addr), .b_gnt_o(b_gnt), .b_valid_o(b_valid), .b_data_o(b_data),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .busy_o(busy)
   );

   font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
      .clk_i(clk), .reset_i(reset),
      .a_req_i(a_req3), .a_addr_i(a_addr3), .a_gnt_o(a_gnt3), .a_valid_o(a_valid3), .a_data_o(a_data3),
      .b_req_i(b_req3), .b_addr_i(b_addr3), .b_gnt_o(b_gnt3), .b_valid_o(b_valid3), .b_data_o(b_data3),
      .rom_addr_o(rom_addr3), .rom_data_i(rom_data3), .busy_o(busy3)
   );

   // Font ROM contents: a fixed scramble of the address.
   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return a[7:0] ^ {a[10:8], a[2:0], 2'b01};
   endfunction

   // Synchronous ROM models with latency 1 and 3.
   logic [7:0] p3_0, p3_1, p3_2;
   always @(posedge clk) begin
      rom_data <= rom_f(rom_addr);
      p3_0     <= rom_f(rom_addr3);
      p3_1     <= p3_0;
      p3_2     <= p3_1;
   end
   assign rom_data3 = p3_2;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Scoreboard: expected grants are queued by the stimulus; each observed
   // grant pops one and queues the expected data strobe two cycles later.
   typedef struct packed { logic port; logic [10:0] addr; } gexp_t;
   typedef struct packed { logic port; logic [7:0] data; int due; } dexp_t;
   gexp_t exp_q[$];
   dexp_t pend_q[$];
   int    gnt_cycs[$];
   int    ncyc = 0, gnt_seen = 0, val_seen = 0, a3_valids = 0;

   always @(negedge clk) begin
      gexp_t ge;
      dexp_t de;
      if (a_valid3) a3_valids++;
      if (reset) begin
         pend_q.delete();
      end else begin
         if (a_gnt && b_gnt)     check_eq("gnt_both_ports", 1, 0);
         if (a_valid && b_valid) check_eq("valid_both_ports", 1, 0);
         if (a_gnt || b_gnt) begin
            gnt_seen++;
            gnt_cycs.push_back(ncyc);
            if (exp_q.size() == 0) begin
               check_eq("gnt_unexpected", {31'd0, b_gnt}, 32'hFFFF_FFFF);
            end else begin
               ge = exp_q.pop_front();
               check_eq("gnt_port", {31'd0, b_gnt}, {31'd0, ge.port});
               check_eq("gnt_rom_addr", {21'd0, rom_addr}, {21'd0, ge.addr});
               pend_q.push_back('{ge.port, rom_f(ge.addr), ncyc + 2});
            end
         end
         if (a_valid || b_valid) begin
            val_seen++;
            if (pend_q.size() == 0) begin
               check_eq("valid_unexpected", {31'd0, b_valid}, 32'hFFFF_FFFF);
            end else begin
               de = pend_q.pop_front();
               check_eq("valid_port", {31'd0, b_valid}, {31'd0, de.port});
               check_eq("valid_data", {24'd0, (b_valid ? b_data : a_data)}, {24'd0, de.data});
               check_eq("valid_cycle", ncyc, de.due);
            end
         end
      end
      ncyc++;
   end

   task automatic wait_gnt(input int target);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk); #1;
         if (gnt_seen >= target) return;
      end
      check_eq("timeout_gnt", gnt_seen, target);
   endtask

   task automatic wait_val(input int target);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk); #1;
         if (val_seen >= target) return;
      end
      check_eq("timeout_valid", val_seen, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, v0, n;
      reset = 1'b1;
      a_req = 0; b_req = 0; a_addr = '0; b_addr = '0;
      a_req3 = 0; b_req3 = 0; a_addr3 = '0; b_addr3 = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_busy", {31'd0, busy}, 0);
      check_eq("rst_outs", {28'd0, a_gnt, b_gnt, a_valid, b_valid}, 0);
      check_eq("rst_data", {16'd0, a_data, b_data}, 0);
      check_eq("rst_rom_addr", {21'd0, rom_addr}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;

      // Single A access, ROM_LAT=1.
      g0 = gnt_seen; v0 = val_seen;
      exp_q.push_back('{1'b0, 11'h041});
      a_addr = 11'h041; a_req = 1;
      wait_gnt(g0 + 1);
      a_req = 0;
      check_eq("t1_busy", {31'd0, busy}, 1);
      wait_val(v0 + 1);
      check_eq("t1_a_data", {24'd0, a_data}, {24'd0, rom_f(11'h041)});
      check_eq("t1_b_data", {24'd0, b_data}, 0);

      // Single B access on the ROM_LAT=3 instance.
      b_addr3 = 11'h7FF; b_req3 = 1;
      n = 0;
      while (!b_gnt3 && n < 40) begin @(negedge clk); #1; n++; end
      check_eq("t2_gnt_seen", {31'd0, b_gnt3}, 1);
      check_eq("t2_rom_addr", {21'd0, rom_addr3}, 32'h7FF);
      b_req3 = 0;
      n = 0;
      while (!b_valid3 && n < 40) begin @(negedge clk); #1; n++; end
      check_eq("t2_valid_delay", n, 4);
      check_eq("t2_b_data", {24'd0, b_data3}, {24'd0, rom_f(11'h7FF)});
      check_eq("t2_a_data", {24'd0, a_data3}, 0);
      check_eq("t2_a_valid", a3_valids, 0);

      // Simultaneous A and B: A first, then B.
      g0 = gnt_seen; v0 = val_seen;
      exp_q.push_back('{1'b0, 11'h123});
      exp_q.push_back('{1'b1, 11'h456});
      a_addr = 11'h123; b_addr = 11'h456; a_req = 1; b_req = 1;
      wait_gnt(g0 + 1);
      a_req = 0;
      wait_gnt(g0 + 2);
      b_req = 0;
      wait_val(v0 + 2);

      // Both held high: A x4 then forced B, repeated; starve count was
      // cleared by the B grant above.
      g0 = gnt_seen; v0 = val_seen;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 11'h200});
         exp_q.push_back('{1'b1, 11'h300});
      end
      a_addr = 11'h200; b_addr = 11'h300; a_req = 1; b_req = 1;
      wait_gnt(g0 + 10);
      a_req = 0; b_req = 0;
      wait_val(v0 + 10);
      for (int i = 1; i < 10; i++)
         check_eq("t4_spacing", gnt_cycs[g0 + i] - gnt_cycs[g0 + i - 1], 3);

      // Reset during WAIT discards the access.
      g0 = gnt_seen; v0 = val_seen;
      exp_q.push_back('{1'b0, 11'h555});
      a_addr = 11'h555; a_req = 1;
      wait_gnt(g0 + 1);
      a_req = 0; reset = 1;
      @(negedge clk); #1;
      check_eq("t5_busy", {31'd0, busy}, 0);
      check_eq("t5_outs", {28'd0, a_gnt, b_gnt, a_valid, b_valid}, 0);
      check_eq("t5_data", {16'd0, a_data, b_data}, 0);
      check_eq("t5_rom_addr", {21'd0, rom_addr}, 0);
      reset = 0;
      repeat (5) @(negedge clk);
      #1;
      check_eq("t5_no_valid", val_seen, v0);
      exp_q.push_back('{1'b0, 11'h0AB});
      a_addr = 11'h0AB; a_req = 1;
      wait_gnt(g0 + 2);
      a_req = 0;
      wait_val(v0 + 1);
      check_eq("t5_a_data", {24'd0, a_data}, {24'd0, rom_f(11'h0AB)});

      // A raises and withdraws its request while B's access is in flight.
      g0 = gnt_seen; v0 = val_seen;
      exp_q.push_back('{1'b1, 11'h010});
      b_addr = 11'h010; b_req = 1;
      wait_gnt(g0 + 1);
      b_req = 0; a_addr = 11'h099; a_req = 1;
      wait_val(v0 + 1);
      a_req = 0;
      repeat (10) @(negedge clk);
      #1;
      check_eq("t6_no_gnt", gnt_seen, g0 + 1);
      check_eq("t6_idle", {31'd0, busy}, 0);

      check_eq("end_exp_empty", exp_q.size(), 0);
      check_eq("end_pend_empty", pend_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
